// File: rtl/mux_2to1_pkg.sv
// Shared defaults and helpers for the mux_2to1 slice.
// Optional statistics are enabled with MUX_2TO1_STATS_EN.
package mux_2to1_pkg;

  localparam int DEFAULT_WIDTH = 1;
  localparam int DEFAULT_CNT_W = 16;

  // Largest value an unsigned counter of cnt_w bits can hold (cnt_w >= 32 clamps to all-ones).
  function automatic logic [31:0] sat_limit(input int unsigned cnt_w);
    if (cnt_w >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << cnt_w) - 32'd1;
  endfunction

endpackage

// File: rtl/mux_2to1_sw_counter.sv
// Saturating event counter: counts inc pulses and holds at the all-ones limit.
// One-cycle update latency; synchronous active-high reset clears the count.
module mux_2to1_sw_counter
  import mux_2to1_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] SAT = (CNT_W >= 32) ? {CNT_W{1'b1}} : CNT_W'(sat_limit(CNT_W));

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != SAT)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mux_2to1.sv
// 2:1 mux with combinational y, registered y_q, select-change pulse and switch counter.
// Define MUX_2TO1_STATS_EN to build the sw_count counter; otherwise sw_count is tied to 0.
module mux_2to1
  import mux_2to1_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  output logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             select,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] y_q,
  output logic             sel_chg,
  output logic [CNT_W-1:0] sw_count
);

  logic sel_q;
  logic seen;
  logic chg_d;

  // Conditional operator keeps the per-bit merge behaviour for an unknown select.
  assign y = select ? i1 : i0;

  // No change is reported until one post-reset sample of select has been taken.
  assign chg_d = seen && (select != sel_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q     <= '0;
      sel_q   <= 1'b0;
      seen    <= 1'b0;
      sel_chg <= 1'b0;
    end else begin
      y_q     <= y;
      sel_q   <= select;
      seen    <= 1'b1;
      sel_chg <= chg_d;
    end
  end

`ifdef MUX_2TO1_STATS_EN
  mux_2to1_sw_counter #(
    .CNT_W(CNT_W)
  ) u_sw_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (chg_d),
    .count(sw_count)
  );
`else
  assign sw_count = '0;
`endif

endmodule

// File: tb/tb_mux_2to1.sv
// Directed bench for mux_2to1: unclocked mux, registered path, reset, pulses, saturation.
`timescale 1ns/1ps
module tb_mux_2to1;

`ifdef MUX_2TO1_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] i0 = 8'h00;
  logic [7:0] i1 = 8'h00;
  logic       select = 1'b0;

  logic       nc_clk = 1'b0;
  logic       nc_rst = 1'b0;
  logic       nc_i0 = 1'b0;
  logic       nc_i1 = 1'b0;
  logic       nc_sel = 1'b0;
  logic       nc_y, nc_y_q, nc_chg;
  logic [15:0] nc_cnt;

  logic [7:0]  y, y_q, s_y, s_y_q;
  logic        sel_chg, s_chg;
  logic [15:0] sw_count;
  logic [1:0]  s_cnt;

  always #5 clk = ~clk;

  mux_2to1 #(.WIDTH(1), .CNT_W(16)) u_nc (
    .y(nc_y), .i0(nc_i0), .i1(nc_i1), .select(nc_sel), .clk(nc_clk), .rst(nc_rst),
    .y_q(nc_y_q), .sel_chg(nc_chg), .sw_count(nc_cnt)
  );

  mux_2to1 #(.WIDTH(8), .CNT_W(16)) u_dut (
    .y(y), .i0(i0), .i1(i1), .select(select), .clk(clk), .rst(rst),
    .y_q(y_q), .sel_chg(sel_chg), .sw_count(sw_count)
  );

  mux_2to1 #(.WIDTH(8), .CNT_W(2)) u_sat (
    .y(s_y), .i0(i0), .i1(i1), .select(select), .clk(clk), .rst(rst),
    .y_q(s_y_q), .sel_chg(s_chg), .sw_count(s_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ec(input int n);
    return STATS ? n : 0;
  endfunction

  initial begin
    // Unclocked mux, 3 ns settle per vector.
    nc_i0 = 1'b0; nc_i1 = 1'b1; nc_sel = 1'b0; #3 chk("nc_y_010", nc_y, 0);
    nc_sel = 1'b1;                             #3 chk("nc_y_011", nc_y, 1);
    nc_i0 = 1'b1; nc_i1 = 1'b0;                #3 chk("nc_y_101", nc_y, 0);

    // Reset held two edges with select=1.
    i0 = 8'hA5; i1 = 8'h3C; select = 1'b1; rst = 1'b1;
    tick(); tick();
    chk("rst_y_q", y_q, 0);
    chk("rst_chg", sel_chg, 0);
    chk("rst_cnt", sw_count, 0);
    chk("rst_y_passthru", y, 8'h3C);

    // First edge after release: no pulse even though select=1.
    rst = 1'b0;
    tick();
    chk("first_edge_chg", sel_chg, 0);
    chk("y_q_sel1", y_q, 8'h3C);
    chk("first_edge_cnt", sw_count, ec(0));

    select = 1'b0;
    #1 chk("y_sel0", y, 8'hA5);
    tick();
    chk("y_q_sel0", y_q, 8'hA5);
    chk("chg_after_1to0", sel_chg, 1);
    tick();
    chk("chg_drops", sel_chg, 0);

    // Mid-operation reset discards the count; then a clean toggle run.
    rst = 1'b1;
    tick();
    chk("mid_rst_cnt", sw_count, 0);
    chk("mid_rst_y_q", y_q, 0);
    rst = 1'b0;
    tick();
    chk("rel2_chg", sel_chg, 0);

    for (int k = 1; k <= 3; k++) begin
      select = ~select;
      tick();
      chk($sformatf("toggle%0d_chg", k), sel_chg, 1);
      chk($sformatf("toggle%0d_cnt", k), sw_count, ec(k));
      chk($sformatf("toggle%0d_sat", k), s_cnt, ec(k));
    end
    tick();
    chk("hold_chg", sel_chg, 0);
    chk("hold_cnt", sw_count, ec(3));

    // Two more changes: 16-bit counter reaches 5, 2-bit counter stays at 3.
    select = ~select; tick();
    select = ~select; tick();
    chk("five_cnt", sw_count, ec(5));
    chk("five_sat", s_cnt, ec(3));
    chk("five_sat_chg", s_chg, 1);

    // Reset coinciding with a select change: reset wins.
    select = ~select; rst = 1'b1;
    tick();
    chk("rst_win_chg", sel_chg, 0);
    chk("rst_win_cnt", sw_count, 0);
    chk("rst_win_sat", s_cnt, 0);
    rst = 1'b0;
    tick();
    chk("rst_win_rel_chg", sel_chg, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_2to1.md
MUX_2TO1 -- requirements
Module: mux_2to1

Interface
REQ-001 Parameter WIDTH, default 1, data width of i0, i1, y and y_q.
REQ-002 Parameter CNT_W, default 16, width of the select-switch counter sw_count.
REQ-003 clk  input  1  single clock; all sequential logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 i0  input  WIDTH  data input selected when select=0.
REQ-006 i1  input  WIDTH  data input selected when select=1.
REQ-007 select  input  1  selection control.
REQ-008 y  output  WIDTH  combinational mux output.
REQ-009 y_q  output  WIDTH  registered copy of y.
REQ-010 sel_chg  output  1  one-cycle pulse indicating a sampled select change.
REQ-011 sw_count  output  CNT_W  saturating count of sampled select changes.
REQ-012 Positional port order SHALL be y, i0, i1, select, clk, rst, y_q, sel_chg, sw_count, so that 4-port positional instances (y, i0, i1, select) remain legal.

Function
REQ-013 y SHALL equal i0 when select=0 and i1 when select=1; purely combinational, zero latency, independent of clk and rst.
REQ-014 y SHALL be valid with clk unconnected or idle.
REQ-015 With select X/Z, y SHALL be per-bit i0 where i0==i1, otherwise X (conditional-operator semantics).
REQ-016 Each rising clk edge with rst=0: y_q <= y; sel_q (internal) <= select.
REQ-017 sel_chg SHALL be 1 for exactly the cycle after an edge where sampled select differs from sel_q, else 0.
REQ-018 The first edge after reset deassertion SHALL NOT produce sel_chg, even if select=1 (the internal first-sample flag is cleared by reset).
REQ-019 sw_count SHALL increment by 1 on each edge where sel_chg is being set, and saturate at 2^CNT_W-1 with no wrap.
REQ-020 Simultaneous rst=1 and select change: reset wins; no pulse, no count.

Reset
REQ-021 rst=1 at a rising edge SHALL set y_q=0, sel_q=0, sel_chg=0, sw_count=0 and clear the first-sample flag.
REQ-022 Reset mid-operation SHALL discard any pending pulse and the count; y SHALL be unaffected by rst.

Configuration
REQ-023 Macro MUX_2TO1_STATS_EN defined: sw_count implemented per REQ-019.
REQ-024 Macro MUX_2TO1_STATS_EN undefined: sw_count port still present, tied to 0, no counter logic; all other behaviour unchanged.

Structure
REQ-025 Package mux_2to1_pkg SHALL hold default constants DEFAULT_WIDTH=1 and DEFAULT_CNT_W=16, plus the saturation-limit helper function.
REQ-026 The saturating counter SHALL be a sub-module mux_2to1_sw_counter (inputs clk, rst, inc; output count), instantiated only under MUX_2TO1_STATS_EN.

Verification
REQ-027 No clock: (i0,i1,select)=(0,1,0) -> y=0; (0,1,1) -> y=1; (1,0,1) -> y=0, each checked 3 ns after stimulus.
REQ-028 WIDTH=8, i0=8'hA5, i1=8'h3C: select=0 -> y=8'hA5, and y_q=8'hA5 after one edge; select=1 -> y=8'h3C, and y_q=8'h3C after one edge.
REQ-029 rst=1 for 2 edges with select=1 -> y_q=0, sel_chg=0, sw_count=0; release -> no sel_chg on the first edge.
REQ-030 After reset, select toggles 0->1->0->1 on 3 successive edges -> sel_chg high for 3 consecutive cycles, sw_count=3.
REQ-031 CNT_W=2 with STATS_EN: 5 select changes -> sw_count=3 (saturated); assert rst -> sw_count=0.
REQ-032 STATS_EN undefined: same toggles -> sw_count stays 0; sel_chg pulses identical to REQ-030.
